des_iter_decrypt: RTL and testbench



---
 rtl/des_iter_decrypt.sv | 273 +++++++++++++++++++++++++++
 tb/tb_des_iter_decrypt.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_decrypt.sv
// -----------------------------------------------------------------------------
// des_iter_decrypt
//    Iterative DES core, one Feistel round per clock through a single round
//    instance. DECRYPT=1 walks the key schedule backwards (K16..K1) so the
//    same datapath inverts the encryptor; DECRYPT=0 runs forwards (K1..K16).
//
// Ports
//    clk        system clock, rising edge
//    rst        asynchronous active-high reset
//    in_valid   block and key presented
//    in_ready   core is idle and can accept a block
//    in_block   64-bit input block, bit 63 = DES bit 1
//    in_key     64-bit key with parity bits (bits 8,16,..,64 are ignored)
//    out_valid  result available, held until out_ready
//    out_ready  downstream accepts the result
//    out_block  64-bit result
//    busy       high while a block is in flight or waiting to be taken
//
// des_round
//    One DES Feistel round: L' = R, R' = L ^ P(S(E(R) ^ subkey)).
// -----------------------------------------------------------------------------

module des_round (
   input  logic [47:0] subkey,
   input  logic [31:0] l_in,
   input  logic [31:0] r_in,
   output logic [31:0] l_out,
   output logic [31:0] r_out
);

   // Tables use DES numbering: entry value n selects input bit n, bit 1 = MSB.
   localparam int E_TAB [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_TAB [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   // Each S-box is its 4x16 table read row by row, first entry in the top nibble.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   // Outer bits of the 6-bit group pick the row, inner four pick the column.
   function automatic logic [3:0] sbox_lookup(input logic [255:0] tab, input logic [5:0] b);
      logic [5:0] idx;
      idx = {b[5], b[0], b[4:1]};
      return tab[8'(255 - 4 * idx) -: 4];
   endfunction

   logic [47:0] expanded;
   logic [31:0] s_out;
   logic [31:0] f_out;

   // Round function: expand, mix key, substitute, permute.
   always_comb begin
      expanded = '0;
      for (int i = 0; i < 48; i++) begin
         expanded[6'(47 - i)] = r_in[5'(32 - E_TAB[6'(i)])];
      end
      expanded = expanded ^ subkey;
      s_out = '0;
      for (int k = 0; k < 8; k++) begin
         s_out[5'(31 - 4 * k) -: 4] = sbox_lookup(SBOX[3'(k)], expanded[6'(47 - 6 * k) -: 6]);
      end
      f_out = '0;
      for (int i = 0; i < 32; i++) begin
         f_out[5'(31 - i)] = s_out[5'(32 - P_TAB[5'(i)])];
      end
   end

   assign l_out = r_in;
   assign r_out = l_in ^ f_out;

endmodule

module des_iter_decrypt #(
   parameter logic DECRYPT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_block,
   input  logic [63:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block,
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int IP_TAB [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

   localparam int FP_TAB [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Decrypt starts from C0/D0, which equals C16/D16 because the forward
   // schedule rotates by 28 in total, so K16 needs no rotation.
   localparam logic [1:0] SHIFT_DEC [16] = '{
      2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   localparam logic [1:0] SHIFT_ENC [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         y[6'(63 - i)] = x[6'(64 - IP_TAB[6'(i)])];
      end
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         y[6'(63 - i)] = x[6'(64 - FP_TAB[6'(i)])];
      end
      return y;
   endfunction

   // PC-1 drops the parity bits by never selecting them.
   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) begin
         y[6'(55 - i)] = x[6'(64 - PC1_TAB[6'(i)])];
      end
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) begin
         y[6'(47 - i)] = x[6'(56 - PC2_TAB[6'(i)])];
      end
      return y;
   endfunction

   function automatic logic [27:0] rot28(input logic [27:0] v, input logic [1:0] s);
      logic [27:0] r;
      r = v;
      if (DECRYPT) begin
         case (s)
            2'd1:    r = {v[0], v[27:1]};
            2'd2:    r = {v[1:0], v[27:2]};
            default: r = v;
         endcase
      end else begin
         case (s)
            2'd1:    r = {v[26:0], v[27]};
            2'd2:    r = {v[25:0], v[27:26]};
            default: r = v;
         endcase
      end
      return r;
   endfunction

   logic [1:0]  state;
   logic [3:0]  rnd;
   logic [31:0] l_reg;
   logic [31:0] r_reg;
   logic [27:0] c_reg;
   logic [27:0] d_reg;

   logic [1:0]  shift_amt;
   logic [27:0] c_rot;
   logic [27:0] d_rot;
   logic [47:0] subkey;
   logic [31:0] l_next;
   logic [31:0] r_next;

   // Key schedule for the current round, derived on the fly from C/D.
   always_comb begin
      shift_amt = DECRYPT ? SHIFT_DEC[rnd] : SHIFT_ENC[rnd];
      c_rot     = rot28(c_reg, shift_amt);
      d_rot     = rot28(d_reg, shift_amt);
      subkey    = pc2_perm({c_rot, d_rot});
   end

   des_round u_round (
      .subkey (subkey),
      .l_in   (l_reg),
      .r_in   (r_reg),
      .l_out  (l_next),
      .r_out  (r_next)
   );

   // Control and datapath registers. The result is captured on the last
   // round edge straight from the round output, with the final swap undone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rnd       <= 4'd0;
         l_reg     <= '0;
         r_reg     <= '0;
         c_reg     <= '0;
         d_reg     <= '0;
         out_block <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  {l_reg, r_reg} <= ip_perm(in_block);
                  {c_reg, d_reg} <= pc1_perm(in_key);
                  rnd            <= 4'd0;
                  state          <= S_RUN;
               end
            end
            S_RUN: begin
               l_reg <= l_next;
               r_reg <= r_next;
               c_reg <= c_rot;
               d_reg <= d_rot;
               if (rnd == 4'd15) begin
                  rnd       <= 4'd0;
                  out_block <= fp_perm({r_next, l_next});
                  state     <= S_DONE;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_des_iter_decrypt.sv
// -----------------------------------------------------------------------------
// tb_des_iter_decrypt
//    Bench for des_iter_decrypt with one decrypting and one encrypting
//    instance sharing block, key, out_ready and reset. Known-answer vectors
//    come from a table; random pairs are pushed through the encryptor and then
//    the decryptor and must come back unchanged. Timing expectations: the
//    result appears on the 16th rising edge after the accept edge (the 17th
//    cycle counting the accept cycle) and back-to-back accepts are 18 edges
//    apart with out_ready held high.
// -----------------------------------------------------------------------------

module tb_des_iter_decrypt;

   typedef struct {
      string       name;
      logic        dec;
      logic [63:0] key;
      logic [63:0] blk;
      logic [63:0] exp_blk;
   } vec_t;

   localparam int LATENCY = 16;
   localparam int SPACING = 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_d;
   logic        in_valid_e;
   logic [63:0] in_block;
   logic [63:0] in_key;
   logic        out_ready;

   logic        in_ready_d, out_valid_d, busy_d;
   logic        in_ready_e, out_valid_e, busy_e;
   logic [63:0] out_block_d, out_block_e;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   vec_t vecs [5];

   des_iter_decrypt #(.DECRYPT(1'b1)) dut_dec (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_d),
      .in_ready  (in_ready_d),
      .in_block  (in_block),
      .in_key    (in_key),
      .out_valid (out_valid_d),
      .out_ready (out_ready),
      .out_block (out_block_d),
      .busy      (busy_d)
   );

   des_iter_decrypt #(.DECRYPT(1'b0)) dut_enc (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_e),
      .in_ready  (in_ready_e),
      .in_block  (in_block),
      .in_key    (in_key),
      .out_valid (out_valid_e),
      .out_ready (out_ready),
      .out_block (out_block_e),
      .busy      (busy_e)
   );

   // 10 ns clock and a rising-edge counter used to measure accept spacing.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Waits (bounded) for out_valid on the chosen instance, starting from the
   // negedge right after the accept edge; lat is the edge count, -1 on timeout.
   task automatic wait_result(input logic dec, output logic [63:0] result, output int lat);
      int k;
      k      = 0;
      lat    = -1;
      result = '0;
      while (lat < 0 && k < 40) begin
         @(negedge clk);
         k++;
         if (dec ? out_valid_d : out_valid_e) begin
            lat    = k;
            result = dec ? out_block_d : out_block_e;
         end
      end
   endtask

   // Presents one block with out_ready high, scrambles the inputs right
   // after the accept edge and returns result, latency and accept edge number.
   task automatic apply_stimulus(input logic dec, input logic [63:0] key, input logic [63:0] blk,
                                 output logic [63:0] result, output int lat, output int acc_cyc);
      @(negedge clk);
      in_block  = blk;
      in_key    = key;
      out_ready = 1'b1;
      if (dec) in_valid_d = 1'b1;
      else     in_valid_e = 1'b1;
      check_output("in_ready_before_accept", dec ? in_ready_d : in_ready_e, 64'd1);
      @(negedge clk);
      acc_cyc    = cyc;
      in_valid_d = 1'b0;
      in_valid_e = 1'b0;
      in_block   = {$urandom, $urandom};
      in_key     = {$urandom, $urandom};
      wait_result(dec, result, lat);
   endtask

   initial begin
      logic [63:0] res;
      logic [63:0] ct;
      logic [63:0] r_key;
      logic [63:0] r_blk;
      int          lat;
      int          acc;
      int          prev_acc;

      vecs[0] = '{name:"kat_dec_std",     dec:1'b1, key:64'h133457799BBCDFF1,
                  blk:64'h85E813540F0AB405, exp_blk:64'h0123456789ABCDEF};
      vecs[1] = '{name:"kat_dec_zero",    dec:1'b1, key:64'h0E329232EA6D0D73,
                  blk:64'h0000000000000000, exp_blk:64'h8787878787878787};
      vecs[2] = '{name:"kat_dec_parity",  dec:1'b1, key:64'h0F339333EB6C0C72,
                  blk:64'h0000000000000000, exp_blk:64'h8787878787878787};
      vecs[3] = '{name:"kat_enc_std",     dec:1'b0, key:64'h133457799BBCDFF1,
                  blk:64'h0123456789ABCDEF, exp_blk:64'h85E813540F0AB405};
      vecs[4] = '{name:"kat_enc_8787",    dec:1'b0, key:64'h0E329232EA6D0D73,
                  blk:64'h8787878787878787, exp_blk:64'h0000000000000000};

      // Reset with in_valid asserted: nothing may be accepted.
      rst        = 1'b1;
      in_valid_d = 1'b1;
      in_valid_e = 1'b1;
      in_block   = 64'h85E813540F0AB405;
      in_key     = 64'h133457799BBCDFF1;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_in_ready",  in_ready_d,  64'd1);
      check_output("rst_out_valid", out_valid_d, 64'd0);
      check_output("rst_busy",      busy_d,      64'd0);
      check_output("rst_out_block", out_block_d, 64'd0);
      check_output("rst_busy_enc",  busy_e,      64'd0);
      in_valid_d = 1'b0;
      in_valid_e = 1'b0;
      rst        = 1'b0;
      @(negedge clk);
      check_output("post_rst_idle", in_ready_d, 64'd1);

      $display("[TB] known-answer table");
      prev_acc = 0;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].dec, vecs[i].key, vecs[i].blk, res, lat, acc);
         check_output(vecs[i].name, res, vecs[i].exp_blk);
         check_output("latency", 64'(lat), 64'(LATENCY));
         if (i > 0 && vecs[i].dec == vecs[i-1].dec) begin
            check_output("b2b_spacing", 64'(acc - prev_acc), 64'(SPACING));
         end
         prev_acc = acc;
      end

      $display("[TB] random round trips");
      for (int i = 0; i < 64; i++) begin
         r_key = {$urandom, $urandom};
         r_blk = {$urandom, $urandom};
         apply_stimulus(1'b0, r_key, r_blk, ct, lat, acc);
         check_output("rt_enc_latency", 64'(lat), 64'(LATENCY));
         apply_stimulus(1'b1, r_key, ct, res, lat, acc);
         check_output("rt_plaintext", res, r_blk);
      end

      $display("[TB] backpressure in DONE");
      @(negedge clk);
      in_block   = vecs[0].blk;
      in_key     = vecs[0].key;
      out_ready  = 1'b0;
      in_valid_d = 1'b1;
      @(negedge clk);
      in_valid_d = 1'b0;
      wait_result(1'b1, res, lat);
      check_output("bp_latency", 64'(lat), 64'(LATENCY));
      check_output("bp_result",  res, vecs[0].exp_blk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid_d = ~in_valid_d;
         in_block   = {$urandom, $urandom};
         check_output("bp_hold_block", out_block_d, vecs[0].exp_blk);
         check_output("bp_in_ready",   in_ready_d,  64'd0);
         check_output("bp_out_valid",  out_valid_d, 64'd1);
      end
      @(negedge clk);
      check_output("bp_still_done", out_valid_d, 64'd1);
      in_valid_d = 1'b1;
      in_block   = vecs[1].blk;
      in_key     = vecs[1].key;
      out_ready  = 1'b1;
      @(negedge clk);
      check_output("bp_release_idle",  in_ready_d,  64'd1);
      check_output("bp_release_valid", out_valid_d, 64'd0);
      check_output("bp_release_busy",  busy_d,      64'd0);
      @(negedge clk);
      check_output("bp_next_accept", busy_d, 64'd1);
      in_valid_d = 1'b0;
      in_block   = {$urandom, $urandom};
      wait_result(1'b1, res, lat);
      check_output("bp_next_result",  res, vecs[1].exp_blk);
      check_output("bp_next_latency", 64'(lat), 64'(LATENCY));

      $display("[TB] asynchronous reset mid-run");
      @(negedge clk);
      in_block   = vecs[0].blk;
      in_key     = vecs[0].key;
      in_valid_d = 1'b1;
      @(negedge clk);
      in_valid_d = 1'b0;
      repeat (7) @(negedge clk);
      check_output("abort_busy_before", busy_d, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_output("abort_busy",      busy_d,      64'd0);
      check_output("abort_in_ready",  in_ready_d,  64'd1);
      check_output("abort_out_valid", out_valid_d, 64'd0);
      check_output("abort_out_block", out_block_d, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1'b1, vecs[2].key, vecs[2].blk, res, lat, acc);
      check_output("after_abort_result",  res, vecs[2].exp_blk);
      check_output("after_abort_latency", 64'(lat), 64'(LATENCY));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
